// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter.
// Holds the FSM state encoding and the transaction-owner encoding.
package mem_arb_pkg;

   typedef enum logic {ST_IDLE, ST_WAIT} arb_state_e;
   typedef enum logic {OWN_IF, OWN_D} arb_owner_e;

   localparam int MAX_MEM_LATENCY = 7;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin selector; gnt[0] = fetch, gnt[1] = data.
// The previous winner loses a tie; the history register lives in the caller.
module rr_arb2
   import mem_arb_pkg::*;
(
   input  logic       req_if,
   input  logic       req_d,
   input  arb_owner_e last_grant,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = {req_d, req_if};
      if (req_if && req_d) begin
         gnt = (last_grant == OWN_D) ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
// One transaction in flight; response is returned MEM_LATENCY cycles after the strobe.
//
// state   | meaning
// ST_IDLE | no outstanding transaction, a request may be accepted
// ST_WAIT | one transaction outstanding, counting down to the response
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int MEM_LATENCY = 1
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_valid,
   output logic              if_req_ready,
   input  logic [XLEN-1:0]   if_req_adr,
   output logic              if_rsp_valid,
   output logic [XLEN-1:0]   if_rsp_data,
   input  logic              d_req_valid,
   output logic              d_req_ready,
   input  logic [XLEN-1:0]   d_req_adr,
   input  logic              d_req_we,
   input  logic [XLEN-1:0]   d_req_wdata,
   input  logic [XLEN/8-1:0] d_req_be,
   output logic              d_rsp_valid,
   output logic [XLEN-1:0]   d_rsp_data,
   output logic              mem_req,
   output logic              mem_we,
   output logic [XLEN-1:0]   mem_adr,
   output logic [XLEN-1:0]   mem_wdata,
   output logic [XLEN/8-1:0] mem_be,
   input  logic [XLEN-1:0]   mem_rdata
);

   localparam int             CW       = $clog2(MEM_LATENCY + 1);
   localparam logic [CW-1:0]  CNT_LOAD = CW'(MEM_LATENCY - 1);

   arb_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   arb_owner_e    owner_q, owner_d;
   logic          owner_we_q, owner_we_d;
   arb_owner_e    last_grant_q, last_grant_d;
   logic [1:0]    gnt;

   rr_arb2 u_rr_arb2 (
      .req_if     (if_req_valid),
      .req_d      (d_req_valid),
      .last_grant (last_grant_q),
      .gnt        (gnt)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      owner_d      = owner_q;
      owner_we_d   = owner_we_q;
      last_grant_d = last_grant_q;
      if_req_ready = 1'b0;
      d_req_ready  = 1'b0;
      if_rsp_valid = 1'b0;
      if_rsp_data  = '0;
      d_rsp_valid  = 1'b0;
      d_rsp_data   = '0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_adr      = '0;
      mem_wdata    = '0;
      mem_be       = '0;
      // Outputs are combinational, so they are forced quiet while reset is held.
      if (!rst) begin
         case (state_q)
            ST_IDLE: begin
               if (gnt != 2'b00) begin
                  mem_req      = 1'b1;
                  state_d      = ST_WAIT;
                  cnt_d        = CNT_LOAD;
                  owner_d      = gnt[1] ? OWN_D : OWN_IF;
                  owner_we_d   = gnt[1] & d_req_we;
                  last_grant_d = gnt[1] ? OWN_D : OWN_IF;
                  if (gnt[1]) begin
                     d_req_ready = 1'b1;
                     mem_we      = d_req_we;
                     mem_adr     = d_req_adr;
                     mem_wdata   = d_req_wdata;
                     mem_be      = d_req_be;
                  end else begin
                     if_req_ready = 1'b1;
                     mem_adr      = if_req_adr;
                     mem_be       = '1;
                  end
               end
            end
            ST_WAIT: begin
               if (cnt_q == '0) begin
                  state_d = ST_IDLE;
                  if (owner_q == OWN_D) begin
                     d_rsp_valid = 1'b1;
                     d_rsp_data  = owner_we_q ? '0 : mem_rdata;
                  end else begin
                     if_rsp_valid = 1'b1;
                     if_rsp_data  = mem_rdata;
                  end
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         owner_q      <= OWN_IF;
         owner_we_q   <= 1'b0;
         last_grant_q <= OWN_D;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         owner_q      <= owner_d;
         owner_we_q   <= owner_we_d;
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a latency-1 instance against a timestamp-based reference
// model with random traffic, plus a latency-3 instance with a directed fetch sequence.
module tb_mem_arbiter;

   localparam int XLEN = 32;
   localparam int BW   = XLEN / 8;

   logic clk = 1'b0;
   logic rst;
   logic mem_clr;
   always #5 clk = ~clk;

   logic            a_if_req_valid, a_if_req_ready, a_if_rsp_valid;
   logic [XLEN-1:0] a_if_req_adr, a_if_rsp_data;
   logic            a_d_req_valid, a_d_req_ready, a_d_req_we, a_d_rsp_valid;
   logic [XLEN-1:0] a_d_req_adr, a_d_req_wdata, a_d_rsp_data;
   logic [BW-1:0]   a_d_req_be, a_mem_be;
   logic            a_mem_req, a_mem_we;
   logic [XLEN-1:0] a_mem_adr, a_mem_wdata, a_mem_rdata;

   logic            b_if_req_valid, b_if_req_ready, b_if_rsp_valid;
   logic [XLEN-1:0] b_if_req_adr, b_if_rsp_data;
   logic            b_d_req_valid, b_d_req_ready, b_d_req_we, b_d_rsp_valid;
   logic [XLEN-1:0] b_d_req_adr, b_d_req_wdata, b_d_rsp_data;
   logic [BW-1:0]   b_d_req_be, b_mem_be;
   logic            b_mem_req, b_mem_we;
   logic [XLEN-1:0] b_mem_adr, b_mem_wdata, b_mem_rdata;

   mem_arbiter #(.XLEN(XLEN), .MEM_LATENCY(1)) dut_a (
      .clk(clk), .rst(rst),
      .if_req_valid(a_if_req_valid), .if_req_ready(a_if_req_ready), .if_req_adr(a_if_req_adr),
      .if_rsp_valid(a_if_rsp_valid), .if_rsp_data(a_if_rsp_data),
      .d_req_valid(a_d_req_valid), .d_req_ready(a_d_req_ready), .d_req_adr(a_d_req_adr),
      .d_req_we(a_d_req_we), .d_req_wdata(a_d_req_wdata), .d_req_be(a_d_req_be),
      .d_rsp_valid(a_d_rsp_valid), .d_rsp_data(a_d_rsp_data),
      .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_adr(a_mem_adr), .mem_wdata(a_mem_wdata),
      .mem_be(a_mem_be), .mem_rdata(a_mem_rdata)
   );

   mem_arbiter #(.XLEN(XLEN), .MEM_LATENCY(3)) dut_b (
      .clk(clk), .rst(rst),
      .if_req_valid(b_if_req_valid), .if_req_ready(b_if_req_ready), .if_req_adr(b_if_req_adr),
      .if_rsp_valid(b_if_rsp_valid), .if_rsp_data(b_if_rsp_data),
      .d_req_valid(b_d_req_valid), .d_req_ready(b_d_req_ready), .d_req_adr(b_d_req_adr),
      .d_req_we(b_d_req_we), .d_req_wdata(b_d_req_wdata), .d_req_be(b_d_req_be),
      .d_rsp_valid(b_d_rsp_valid), .d_rsp_data(b_d_rsp_data),
      .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_adr(b_mem_adr), .mem_wdata(b_mem_wdata),
      .mem_be(b_mem_be), .mem_rdata(b_mem_rdata)
   );

   // Memory for instance A: 256 words, read data one cycle after the strobe.
   logic [XLEN-1:0] mem_a [0:255];
   logic [XLEN-1:0] a_rd;
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 256; i++) mem_a[i] <= '0;
         mem_a[4] <= 32'h0000_0013;
      end else if (a_mem_req) begin
         if (a_mem_we) begin
            for (int b = 0; b < BW; b++)
               if (a_mem_be[b]) mem_a[a_mem_adr[9:2]][8*b +: 8] <= a_mem_wdata[8*b +: 8];
         end else begin
            a_rd <= mem_a[a_mem_adr[9:2]];
         end
      end
   end
   assign a_mem_rdata = a_rd;

   // Memory for instance B: address-derived data, three-cycle read pipeline.
   logic [XLEN-1:0] b_rd0, b_rd1, b_rd2;
   always @(posedge clk) begin
      b_rd0 <= b_mem_req ? (b_mem_adr ^ 32'hA5A5_0000) : 32'h0;
      b_rd1 <= b_rd0;
      b_rd2 <= b_rd1;
   end
   assign b_mem_rdata = b_rd2;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: a transaction accepted at cycle c answers at c+1 and frees the port at c+2.
   logic [XLEN-1:0] ref_mem [0:255];
   int              cyc, resp_at, free_at;
   bit              own_d, last_d;
   logic [XLEN-1:0] rsp_val;
   bit              acc_if, acc_d;

   task automatic model_reset();
      cyc = 0; resp_at = -1; free_at = 0; own_d = 0; last_d = 1;
   endtask

   task automatic step_a();
      bit              e_if_rdy, e_d_rdy, e_req, e_we, e_ifv, e_dv, sel_d;
      logic [XLEN-1:0] e_adr, e_wd, e_ifd, e_dd;
      logic [BW-1:0]   e_be;
      logic [7:0]      idx;
      e_if_rdy = 0; e_d_rdy = 0; e_req = 0; e_we = 0; e_ifv = 0; e_dv = 0;
      e_adr = '0; e_wd = '0; e_ifd = '0; e_dd = '0; e_be = '0;
      acc_if = 0; acc_d = 0;
      if (cyc < free_at) begin
         if (cyc == resp_at) begin
            if (own_d) begin e_dv = 1; e_dd = rsp_val; end
            else begin e_ifv = 1; e_ifd = rsp_val; end
         end
      end else if (a_if_req_valid || a_d_req_valid) begin
         sel_d = (a_if_req_valid && a_d_req_valid) ? !last_d : a_d_req_valid;
         e_req = 1;
         if (sel_d) begin
            e_d_rdy = 1; acc_d = 1;
            e_adr = a_d_req_adr; e_we = a_d_req_we; e_wd = a_d_req_wdata; e_be = a_d_req_be;
         end else begin
            e_if_rdy = 1; acc_if = 1;
            e_adr = a_if_req_adr; e_be = '1;
         end
         idx = e_adr[9:2];
         rsp_val = (sel_d && e_we) ? '0 : ref_mem[idx];
         if (sel_d && e_we)
            for (int b = 0; b < BW; b++)
               if (e_be[b]) ref_mem[idx][8*b +: 8] = e_wd[8*b +: 8];
         own_d = sel_d; last_d = sel_d;
         resp_at = cyc + 1; free_at = cyc + 2;
      end
      chk("if_req_ready", a_if_req_ready, e_if_rdy);
      chk("d_req_ready", a_d_req_ready, e_d_rdy);
      chk("mem_req", a_mem_req, e_req);
      chk("mem_we", a_mem_we, e_we);
      chk("mem_adr", a_mem_adr, e_adr);
      chk("mem_wdata", a_mem_wdata, e_wd);
      chk("mem_be", a_mem_be, e_be);
      chk("if_rsp_valid", a_if_rsp_valid, e_ifv);
      chk("if_rsp_data", a_if_rsp_data, e_ifd);
      chk("d_rsp_valid", a_d_rsp_valid, e_dv);
      chk("d_rsp_data", a_d_rsp_data, e_dd);
      cyc++;
   endtask

   task automatic tick_a();
      @(negedge clk);
      step_a();
      @(posedge clk); #1;
   endtask

   task automatic chk_zero_a(input string tag);
      chk({tag, "_if_rdy"}, a_if_req_ready, 0);
      chk({tag, "_d_rdy"}, a_d_req_ready, 0);
      chk({tag, "_if_rsp"}, a_if_rsp_valid, 0);
      chk({tag, "_d_rsp"}, a_d_rsp_valid, 0);
      chk({tag, "_rsp_data"}, a_if_rsp_data | a_d_rsp_data, 0);
      chk({tag, "_mem_req"}, a_mem_req, 0);
      chk({tag, "_mem_bus"}, a_mem_adr | a_mem_wdata | {31'b0, a_mem_we} | {28'b0, a_mem_be}, 0);
   endtask

   task automatic rst_pulse();
      rst = 1; a_if_req_valid = 0; a_d_req_valid = 0;
      @(negedge clk);
      chk_zero_a("rst");
      @(posedge clk); #1;
      rst = 0;
      model_reset();
   endtask

   function automatic logic [XLEN-1:0] rnd_adr();
      logic [7:0] w;
      w = 8'($urandom_range(0, 255));
      return {22'h0, w, 2'b00};
   endfunction

   logic [XLEN-1:0] b_exp_adr [0:8] = '{32'h40, 0, 0, 0, 32'h44, 0, 0, 0, 0};
   logic            b_exp_rdy [0:8] = '{1, 0, 0, 0, 1, 0, 0, 0, 0};
   logic            b_exp_rsp [0:8] = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
   logic [XLEN-1:0] b_exp_dat [0:8] = '{0, 0, 0, 32'hA5A5_0040, 0, 0, 0, 32'hA5A5_0044, 0};

   initial begin
      int n;
      rst = 1; mem_clr = 1;
      a_if_req_valid = 1; a_if_req_adr = 32'h10;
      a_d_req_valid = 1; a_d_req_adr = 32'h20; a_d_req_we = 1; a_d_req_wdata = 32'h1234; a_d_req_be = '1;
      b_if_req_valid = 1; b_if_req_adr = 32'h40;
      b_d_req_valid = 0; b_d_req_adr = '0; b_d_req_we = 0; b_d_req_wdata = '0; b_d_req_be = '0;
      for (int i = 0; i < 256; i++) ref_mem[i] = '0;
      ref_mem[4] = 32'h0000_0013;

      // Requests held during reset must see no ready and a quiet memory bus.
      @(posedge clk); #1;
      @(negedge clk);
      chk_zero_a("in_rst");
      chk("in_rst_b_rdy", b_if_req_ready, 0);
      @(posedge clk); #1;
      rst = 0; mem_clr = 0;
      a_if_req_valid = 0; a_d_req_valid = 0; b_if_req_valid = 0;
      model_reset();

      // Single fetch, latency 1.
      a_if_req_valid = 1; a_if_req_adr = 32'h10;
      @(negedge clk);
      chk("fetch_ready", a_if_req_ready, 1);
      chk("fetch_adr", a_mem_adr, 32'h10);
      step_a();
      @(posedge clk); #1;
      a_if_req_valid = 0;
      @(negedge clk);
      chk("fetch_rsp_valid", a_if_rsp_valid, 1);
      chk("fetch_rsp_data", a_if_rsp_data, 32'h13);
      step_a();
      @(posedge clk); #1;

      // Partial store then load-back.
      a_d_req_valid = 1; a_d_req_adr = 32'h100; a_d_req_we = 1;
      a_d_req_wdata = 32'hDEAD_BEEF; a_d_req_be = 4'b0011;
      tick_a();
      a_d_req_valid = 0;
      @(negedge clk);
      chk("store_ack_valid", a_d_rsp_valid, 1);
      chk("store_ack_data", a_d_rsp_data, 0);
      step_a();
      @(posedge clk); #1;
      a_d_req_valid = 1; a_d_req_we = 0;
      tick_a();
      a_d_req_valid = 0;
      @(negedge clk);
      chk("load_back_data", a_d_rsp_data, 32'h0000_BEEF);
      step_a();
      @(posedge clk); #1;

      // Reset one cycle after a load is accepted: the response must never appear.
      a_d_req_valid = 1; a_d_req_we = 0; a_d_req_adr = 32'h100;
      tick_a();
      rst = 1; a_d_req_valid = 0;
      @(negedge clk);
      chk_zero_a("mid_rst");
      @(posedge clk); #1;
      rst = 0; model_reset();
      a_if_req_valid = 1; a_if_req_adr = 32'h10; a_d_req_valid = 1;
      @(negedge clk);
      chk("post_rst_if_gnt", a_if_req_ready, 1);
      chk("post_rst_d_gnt", a_d_req_ready, 0);
      step_a();
      @(posedge clk); #1;

      // Random traffic; requesters hold their request until it is accepted.
      for (int i = 0; i < 400; i++) begin
         tick_a();
         if (acc_if || !a_if_req_valid) begin
            a_if_req_valid = ($urandom_range(0, 9) < 5);
            a_if_req_adr = rnd_adr();
         end
         if (acc_d || !a_d_req_valid) begin
            a_d_req_valid = ($urandom_range(0, 9) < 5);
            a_d_req_adr = rnd_adr();
            a_d_req_we = 1'($urandom_range(0, 1));
            a_d_req_wdata = $urandom;
            a_d_req_be = 4'($urandom_range(0, 15));
         end
      end

      // Both requesters permanently valid: grants alternate IF, D every two cycles.
      rst_pulse();
      a_if_req_valid = 1; a_if_req_adr = rnd_adr();
      a_d_req_valid = 1; a_d_req_we = 0; a_d_req_adr = rnd_adr();
      n = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (a_if_req_ready || a_d_req_ready) begin
            chk("rr_order", a_d_req_ready, 32'(n % 2));
            chk("rr_spacing", i, 2 * n);
            n++;
         end
         step_a();
         @(posedge clk); #1;
         if (acc_if) a_if_req_adr = rnd_adr();
         if (acc_d) a_d_req_adr = rnd_adr();
      end
      chk("rr_count", n, 8);
      a_if_req_valid = 0; a_d_req_valid = 0;

      // Latency 3: ready only in accept cycles, held request waits for ST_IDLE.
      b_if_req_valid = 1; b_if_req_adr = 32'h40;
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         chk("b_ready", b_if_req_ready, b_exp_rdy[k]);
         chk("b_mem_req", b_mem_req, b_exp_rdy[k]);
         chk("b_mem_adr", b_mem_adr, b_exp_adr[k]);
         chk("b_rsp_valid", b_if_rsp_valid, b_exp_rsp[k]);
         chk("b_rsp_data", b_if_rsp_data, b_exp_dat[k]);
         chk("b_d_rsp_valid", b_d_rsp_valid, 0);
         @(posedge clk); #1;
         if (k == 0) b_if_req_adr = 32'h44;
         if (k == 4) b_if_req_valid = 0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
